// File: rtl/uart_fifo_v2.sv
// rtl/uart_fifo_v2.sv - parametrised synchronous FIFO for the UART RX/TX paths
// Optional first-word-fall-through read, fill level, thresholds, sticky errors, flush.
module uart_fifo_v2 #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = 14,
    parameter int AE_THRESH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] AF_L = LW'(AF_THRESH);
    localparam logic [LW-1:0] AE_L = LW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [LW-1:0]         wr_ptr;
    logic [LW-1:0]         rd_ptr;
    logic [LW-1:0]         level_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  wr_ok;
    logic                  rd_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);

    assign wr_ok = wr_en && !full && !flush;
    assign rd_ok = rd_en && !empty && !flush;

    assign level        = level_q;
    assign almost_full  = (level_q >= AF_L);
    assign almost_empty = (level_q <= AE_L);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + LW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + LW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Requests ignored under flush do not raise errors; a new event beats clr_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_en && full && !flush) begin
                overflow_q <= 1'b1;
            end else if (clr_err) begin
                overflow_q <= 1'b0;
            end
            if (rd_en && empty && !flush) begin
                underflow_q <= 1'b1;
            end else if (clr_err) begin
                underflow_q <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rd_data  = mem[rd_ptr[AW-1:0]];
            assign rd_valid = !empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rd_data_q;
            logic                  rd_valid_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else if (rd_ok) begin
                    rd_data_q  <= mem[rd_ptr[AW-1:0]];
                    rd_valid_q <= 1'b1;
                end else begin
                    rd_valid_q <= 1'b0;
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_uart_fifo_v2.sv
// tb/tb_uart_fifo_v2.sv - self-checking bench for uart_fifo_v2
// Standard 16x16 instance against a queue model, plus a 4x8 first-word-fall-through instance.
module tb_uart_fifo_v2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        flush = 0, wr_en = 0, rd_en = 0, clr_err = 0;
    logic [15:0] wr_data = '0;
    logic [15:0] rd_data;
    logic        rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0]  level;

    logic        f4 = 0, w4 = 0, r4 = 0, c4 = 0;
    logic [7:0]  d4 = '0;
    logic [7:0]  rd4;
    logic        rv4, full4, empty4, af4, ae4, ovf4, unf4;
    logic [2:0]  lvl4;

    uart_fifo_v2 u16 (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .full(full),
        .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .level(level), .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    uart_fifo_v2 #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(1), .AF_THRESH(3), .AE_THRESH(1)) u4 (
        .clk(clk), .rst(rst), .flush(f4), .wr_en(w4), .wr_data(d4),
        .rd_en(r4), .rd_data(rd4), .rd_valid(rv4), .full(full4),
        .empty(empty4), .almost_full(af4), .almost_empty(ae4),
        .level(lvl4), .overflow(ovf4), .underflow(unf4), .clr_err(c4)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: an ordered queue of words plus the error flags and read port.
    logic [15:0] m_q[$];
    logic        m_ovf = 0, m_unf = 0, m_rv = 0;
    logic [15:0] m_rd = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf = 0; m_unf = 0; m_rv = 0; m_rd = '0;
    endtask

    task automatic model_update(input logic f, input logic w, input logic [15:0] d,
                                input logic r, input logic c);
        int n = m_q.size();
        if (!f && w && n == 16) m_ovf = 1;
        else if (c) m_ovf = 0;
        if (!f && r && n == 0) m_unf = 1;
        else if (c) m_unf = 0;
        if (f) begin
            m_q.delete();
            m_rv = 0;
        end else begin
            if (r && n > 0) begin
                m_rd = m_q.pop_front();
                m_rv = 1;
            end else begin
                m_rv = 0;
            end
            if (w && n < 16) m_q.push_back(d);
        end
    endtask

    task automatic step(input logic f, input logic w, input logic [15:0] d,
                        input logic r, input logic c);
        flush = f; wr_en = w; wr_data = d; rd_en = r; clr_err = c;
        @(posedge clk);
        model_update(f, w, d, r, c);
        #1;
        flush = 0; wr_en = 0; rd_en = 0; clr_err = 0;
    endtask

    task automatic check_model(input string tag);
        int n = m_q.size();
        check({tag, " level"},        32'(level),        32'(n));
        check({tag, " full"},         32'(full),         32'(n == 16));
        check({tag, " empty"},        32'(empty),        32'(n == 0));
        check({tag, " almost_full"},  32'(almost_full),  32'(n >= 14));
        check({tag, " almost_empty"}, 32'(almost_empty), 32'(n <= 2));
        check({tag, " overflow"},     32'(overflow),     32'(m_ovf));
        check({tag, " underflow"},    32'(underflow),    32'(m_unf));
        check({tag, " rd_valid"},     32'(rd_valid),     32'(m_rv));
        check({tag, " rd_data"},      32'(rd_data),      32'(m_rd));
    endtask

    task automatic mstep(input string tag, input logic f, input logic w, input logic [15:0] d,
                         input logic r, input logic c);
        step(f, w, d, r, c);
        check_model(tag);
    endtask

    task automatic step4(input logic w, input logic [7:0] d, input logic r);
        w4 = w; d4 = d; r4 = r;
        @(posedge clk);
        #1;
        w4 = 0; r4 = 0;
    endtask

    typedef struct {
        logic        f, w, r, c;
        logic [15:0] d;
        int          lvl;
        logic        emp, rv, unf;
        logic [15:0] rdd;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{f:0, w:1, r:0, c:0, d:16'h0001, lvl:1, emp:0, rv:0, unf:0, rdd:16'h0000};
        vecs[1]  = '{f:0, w:1, r:0, c:0, d:16'h0002, lvl:2, emp:0, rv:0, unf:0, rdd:16'h0000};
        vecs[2]  = '{f:0, w:1, r:1, c:0, d:16'h0003, lvl:2, emp:0, rv:1, unf:0, rdd:16'h0001};
        vecs[3]  = '{f:0, w:0, r:1, c:0, d:16'h0000, lvl:1, emp:0, rv:1, unf:0, rdd:16'h0002};
        vecs[4]  = '{f:0, w:0, r:0, c:0, d:16'h0000, lvl:1, emp:0, rv:0, unf:0, rdd:16'h0002};
        vecs[5]  = '{f:0, w:0, r:1, c:0, d:16'h0000, lvl:0, emp:1, rv:1, unf:0, rdd:16'h0003};
        vecs[6]  = '{f:0, w:0, r:1, c:0, d:16'h0000, lvl:0, emp:1, rv:0, unf:1, rdd:16'h0003};
        vecs[7]  = '{f:0, w:0, r:1, c:1, d:16'h0000, lvl:0, emp:1, rv:0, unf:1, rdd:16'h0003};
        vecs[8]  = '{f:0, w:0, r:0, c:1, d:16'h0000, lvl:0, emp:1, rv:0, unf:0, rdd:16'h0003};
        vecs[9]  = '{f:1, w:1, r:0, c:0, d:16'h00AA, lvl:0, emp:1, rv:0, unf:0, rdd:16'h0003};
        vecs[10] = '{f:0, w:1, r:0, c:0, d:16'h0055, lvl:1, emp:0, rv:0, unf:0, rdd:16'h0003};
        vecs[11] = '{f:0, w:0, r:1, c:0, d:16'h0000, lvl:0, emp:1, rv:1, unf:0, rdd:16'h0055};

        // Reset state of both instances
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        check("reset u4 level", 32'(lvl4), 0);
        check("reset u4 empty", 32'(empty4), 1);
        check("reset u4 rd_valid", 32'(rv4), 0);
        check("reset u4 almost_empty", 32'(ae4), 1);
        rst = 0;
        @(posedge clk);
        #1;

        // Directed table
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].f, vecs[i].w, vecs[i].d, vecs[i].r, vecs[i].c);
            check($sformatf("vec%0d level", i), 32'(level), 32'(vecs[i].lvl));
            check($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].emp));
            check($sformatf("vec%0d rd_valid", i), 32'(rd_valid), 32'(vecs[i].rv));
            check($sformatf("vec%0d underflow", i), 32'(underflow), 32'(vecs[i].unf));
            check($sformatf("vec%0d rd_data", i), 32'(rd_data), 32'(vecs[i].rdd));
            check($sformatf("vec%0d overflow", i), 32'(overflow), 0);
        end

        // Fill to full, overflow on the 17th write, drain in order
        for (int i = 1; i <= 16; i++) mstep("fill", 0, 1, 16'(i), 0, 0);
        check("fill full", 32'(full), 1);
        check("fill level", 32'(level), 16);
        mstep("ovf", 0, 1, 16'hDEAD, 0, 0);
        check("ovf flag", 32'(overflow), 1);
        for (int i = 1; i <= 16; i++) begin
            mstep("drain", 0, 0, 16'h0, 1, 0);
            check("drain word", 32'(rd_data), 32'(i));
        end
        mstep("drain idle", 0, 0, 16'h0, 0, 1);
        check("drained empty", 32'(empty), 1);

        // Pointer wrap
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 12; i++) mstep("wrap wr", 0, 1, 16'($urandom), 0, 0);
            for (int i = 0; i < 12; i++) mstep("wrap rd", 0, 0, 16'h0, 1, 0);
        end
        check("wrap level", 32'(level), 0);

        // Simultaneous read/write at level 5, then at full
        for (int i = 0; i < 5; i++) mstep("lvl5 fill", 0, 1, 16'($urandom), 0, 0);
        for (int i = 0; i < 20; i++) mstep("lvl5 rw", 0, 1, 16'($urandom), 1, 0);
        check("lvl5 level", 32'(level), 5);
        for (int i = 0; i < 11; i++) mstep("top fill", 0, 1, 16'($urandom), 0, 0);
        mstep("full rw", 0, 1, 16'hBEEF, 1, 0);
        check("full rw level", 32'(level), 15);
        check("full rw overflow", 32'(overflow), 1);

        // Flush at level 7 with a write; overflow keeps its value
        while (m_q.size() > 7) mstep("to7", 0, 0, 16'h0, 1, 0);
        mstep("flush", 1, 1, 16'h7777, 0, 0);
        check("flush level", 32'(level), 0);
        check("flush overflow kept", 32'(overflow), 1);
        mstep("clr", 0, 0, 16'h0, 0, 1);

        // Asynchronous reset mid-cycle at level 3
        for (int i = 0; i < 3; i++) mstep("pre rst", 0, 1, 16'($urandom), 0, 0);
        #2;
        rst = 1;
        #1;
        model_reset();
        check_model("async rst");
        @(posedge clk);
        #1;
        rst = 0;
        mstep("post rst wr", 0, 1, 16'h1234, 0, 0);
        mstep("post rst rd", 0, 0, 16'h0, 1, 0);
        check("post rst data", 32'(rd_data), 32'h1234);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            mstep("rand", ($urandom_range(0, 49) == 0), ($urandom_range(0, 99) < 55),
                  16'($urandom), ($urandom_range(0, 99) < 45), ($urandom_range(0, 19) == 0));
        end

        // First-word-fall-through instance
        step4(1, 8'hA5, 0);
        check("fwft data", 32'(rd4), 32'hA5);
        check("fwft valid", 32'(rv4), 1);
        step4(0, 8'h00, 1);
        check("fwft pop empty", 32'(empty4), 1);
        check("fwft pop valid", 32'(rv4), 0);
        step4(1, 8'h11, 0);
        step4(1, 8'h22, 0);
        step4(1, 8'h33, 0);
        check("fwft af", 32'(af4), 1);
        step4(1, 8'h44, 0);
        check("fwft full", 32'(full4), 1);
        check("fwft level4", 32'(lvl4), 4);
        check("fwft head", 32'(rd4), 32'h11);
        step4(1, 8'h55, 0);
        check("fwft overflow", 32'(ovf4), 1);
        step4(0, 8'h00, 1);
        check("fwft head2", 32'(rd4), 32'h22);
        step4(1, 8'h66, 1);
        check("fwft rw level", 32'(lvl4), 3);
        check("fwft head3", 32'(rd4), 32'h33);
        step4(0, 8'h00, 1);
        check("fwft head4", 32'(rd4), 32'h44);
        step4(0, 8'h00, 1);
        check("fwft head5", 32'(rd4), 32'h66);
        step4(0, 8'h00, 1);
        check("fwft final empty", 32'(empty4), 1);
        check("fwft underflow clear", 32'(unf4), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
